// File: rtl/cpu_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings,
// the default table index width and the sequential PC step.
package cpu_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int IDX_W_DEF = 6;
  localparam int PC_INC    = 4;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating taken/not-taken counter.
module sat_counter2
  import cpu_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = state + 2'd1;
    end else begin
      if (state != SNT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor with registered mispredict flush/redirect
// and saturating branch/mispredict statistics.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic [PC_W-1:0]  res_pc_i,
  input  logic             res_pred_i,
  input  logic             res_taken_i,
  input  logic [PC_W-1:0]  res_target_i,
  output logic             flush_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       tbl [ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       upd_next;
  logic             miss;
  logic             unused_bits;

  assign pred_idx     = pred_pc_i[IDX_W+1:2];
  assign res_idx      = res_pc_i[IDX_W+1:2];
  assign pred_taken_o = tbl[pred_idx][1];
  assign miss         = res_valid_i && (res_pred_i != res_taken_i);

  // Low and high PC bits do not select an entry; aliasing is accepted.
  assign unused_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

  sat_counter2 u_sat (
    .state      (tbl[res_idx]),
    .taken      (res_taken_i),
    .next_state (upd_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
    end else if (res_valid_i) begin
      tbl[res_idx] <= upd_next;
    end
  end

  // Redirect only loads on a miss so res_* garbage never reaches state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      flush_o <= miss;
      if (miss) begin
        redirect_pc_o <= res_taken_i ? res_target_i : res_pc_i + PC_W'(PC_INC);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (res_valid_i && (branch_cnt_o != '1)) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (miss && (miss_cnt_o != '1))          miss_cnt_o   <= miss_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps plus randomized
// resolutions checked against an arithmetic model of the counter table.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_pred;
  logic        res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model: counter values 0..3 per entry, plain integers
  int          m_tab [64];
  int          m_bcnt;
  int          m_mcnt;
  logic        m_flush;
  logic [31:0] m_redir;

  branch_predictor dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pred_pc_i     (pred_pc),
    .pred_taken_o  (pred_taken),
    .res_valid_i   (res_valid),
    .res_pc_i      (res_pc),
    .res_pred_i    (res_pred),
    .res_taken_i   (res_taken),
    .res_target_i  (res_target),
    .flush_o       (flush),
    .redirect_pc_o (redirect_pc),
    .branch_cnt_o  (branch_cnt),
    .miss_cnt_o    (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tab[i] = 1;
    m_bcnt  = 0;
    m_mcnt  = 0;
    m_flush = 1'b0;
    m_redir = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".flush"},    {31'b0, flush}, {31'b0, m_flush});
    check({tag, ".redirect"}, redirect_pc, m_redir);
    check({tag, ".bcnt"},     {16'b0, branch_cnt}, 32'(m_bcnt));
    check({tag, ".mcnt"},     {16'b0, miss_cnt},   32'(m_mcnt));
  endtask

  // one cycle: drive, check the combinational prediction, clock, check registers
  task automatic apply(input string tag, input logic v, input logic [31:0] pc,
                       input logic pr, input logic tk, input logic [31:0] tg,
                       input logic [31:0] ppc, input logic full);
    int i;
    res_valid  = v;
    res_pc     = pc;
    res_pred   = pr;
    res_taken  = tk;
    res_target = tg;
    pred_pc    = ppc;
    #2;
    check({tag, ".pred"}, {31'b0, pred_taken}, {31'b0, m_tab[midx(ppc)] >= 2});
    @(posedge clk);
    m_flush = v && (pr != tk);
    if (m_flush) m_redir = tk ? tg : pc + 32'd4;
    if (v) begin
      i = midx(pc);
      if (tk) m_tab[i] = (m_tab[i] == 3) ? 3 : m_tab[i] + 1;
      else    m_tab[i] = (m_tab[i] == 0) ? 0 : m_tab[i] - 1;
      if (m_bcnt < 65535) m_bcnt++;
      if (m_flush && m_mcnt < 65535) m_mcnt++;
    end
    #1;
    if (full) check_regs(tag);
    else check({tag, ".flush"}, {31'b0, flush}, {31'b0, m_flush});
  endtask

  initial begin
    logic tk;
    rst        = 1'b1;
    res_valid  = 1'b0;
    res_pc     = '0;
    res_pred   = 1'b0;
    res_taken  = 1'b0;
    res_target = '0;
    pred_pc    = 32'h40;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    #1;
    check("rst.pred", {31'b0, pred_taken}, 32'd0);
    check_regs("rst");

    // 2: taken mispredict of 0x40, then a correctly predicted taken
    apply("t2a", 1, 32'h40, 0, 1, 32'h100, 32'h40, 1);
    check("t2a.redir_abs", redirect_pc, 32'h100);
    check("t2a.flush_abs", {31'b0, flush}, 32'd1);
    apply("t2b", 1, 32'h40, 1, 1, 32'h100, 32'h40, 1);
    check("t2b.flush_abs", {31'b0, flush}, 32'd0);

    // 3: not-taken mispredict from ST; aliasing PC 0x140 reads the same entry
    apply("t3a", 1, 32'h40, 1, 0, 32'h100, 32'h140, 1);
    check("t3a.redir_abs", redirect_pc, 32'h44);
    apply("t3b", 0, 32'h0, 0, 0, 32'h0, 32'h140, 1);
    check("t3b.alias_pred", {31'b0, pred_taken}, 32'd1);

    // 4: read and update the same index in one cycle (no bypass)
    apply("t4a", 1, 32'h80, 0, 1, 32'h200, 32'h80, 1);
    apply("t4b", 0, 32'h0, 0, 0, 32'h0, 32'h80, 1);

    // idle cycles with junk on res_* must not disturb anything
    for (int k = 0; k < 8; k++)
      apply("idle", 0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 32'h80, 1);

    // randomized mixed traffic over a narrow PC range to exercise saturation
    for (int k = 0; k < 400; k++)
      apply("rnd", $urandom_range(0, 3) != 0, {$urandom_range(0, 255), 2'($urandom)},
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
            {$urandom_range(0, 255), 2'($urandom)}, 1);

    // 5: drive both statistics to 0xFFFE with back-to-back mispredicts
    rst = 1'b1;
    #1 model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 65534; k++) begin
      tk = 1'($urandom_range(0, 1));
      apply("bulk", 1, $urandom, ~tk, tk, $urandom, $urandom, 0);
    end
    check_regs("t5.fffe");
    check("t5.bcnt_abs", {16'b0, branch_cnt}, 32'hFFFE);
    apply("t5a", 1, 32'h10, 0, 1, 32'h20, 32'h10, 1);
    check("t5a.mcnt_abs", {16'b0, miss_cnt}, 32'hFFFF);
    apply("t5b", 1, 32'h10, 1, 0, 32'h20, 32'h10, 1);
    apply("t5c", 1, 32'hFFFF_FFFC, 1, 0, 32'h1234, 32'h10, 1);
    check("t5c.wrap", redirect_pc, 32'h0);
    check("t5c.bcnt_hold", {16'b0, branch_cnt}, 32'hFFFF);
    check("t5c.mcnt_hold", {16'b0, miss_cnt}, 32'hFFFF);

    // 6: async reset between a mispredict and its flush edge
    apply("t6pre", 1, 32'h40, 0, 1, 32'h300, 32'h40, 1);
    res_valid  = 1'b1;
    res_pc     = 32'h40;
    res_pred   = 1'b1;
    res_taken  = 1'b0;
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("t6.flush_async", {31'b0, flush}, 32'd0);
    check_regs("t6.async");
    @(posedge clk);
    #1;
    check_regs("t6.held");
    res_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      pred_pc = 32'(k * 4);
      #1 check("t6.entry", {31'b0, pred_taken}, 32'd0);
    end
    apply("t6post", 0, 32'h0, 0, 0, 32'h0, 32'h40, 1);
    apply("t6first", 1, 32'h44, 0, 1, 32'h500, 32'h44, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and redirect generator for the pipelined MIPS core.
- Sits directly downstream of Branch_Check. It consumes the resolved taken/not-taken decision, updates a table of 2-bit saturating counters, and raises a registered flush/redirect when the prediction made at IF was wrong.
- Also provides IF with a per-PC taken prediction.

Parameters:
- IDX_W, 6, index width; the table has 2**IDX_W entries.
- PC_W, 32, width of PC and target buses.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pred_pc_i  in  PC_W  PC of the instruction currently in IF.
- pred_taken_o  out  1  prediction for pred_pc_i: 1 = taken. Combinational.
- res_valid_i  in  1  a branch resolves this cycle (Branch_i of the resolving stage).
- res_pc_i  in  PC_W  PC of the resolving branch.
- res_pred_i  in  1  prediction originally issued for that branch, carried down the pipeline.
- res_taken_i  in  1  actual outcome (Branch_o of Branch_Check).
- res_target_i  in  PC_W  branch target address.
- flush_o  out  1  registered one-cycle pulse: flush younger instructions.
- redirect_pc_o  out  PC_W  registered correct fetch PC; valid while flush_o = 1.
- branch_cnt_o  out  CNT_W  number of resolved branches, saturating.
- miss_cnt_o  out  CNT_W  number of mispredictions, saturating.

Behaviour:
- Reset (async assert, sync release):
  - every table entry = WNT (01);
  - flush_o = 0, redirect_pc_o = 0;
  - branch_cnt_o = 0, miss_cnt_o = 0.
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored; aliasing between PCs is allowed.
- Counter states and encoding: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - pred_taken_o = entry[idx(pred_pc_i)][1].
- Update, on any edge with res_valid_i = 1:
  - taken: SNT→WNT→WT→ST, ST holds;
  - not taken: ST→WT→WNT→SNT, SNT holds.
  - No update when res_valid_i = 0.
- Simultaneous read and update of the same index: pred_taken_o reflects the pre-update value (read-before-write, no bypass).
- Mispredict: miss = res_valid_i & (res_pred_i != res_taken_i). On the next edge:
  - flush_o <= miss;
  - redirect_pc_o <= res_taken_i ? res_target_i : res_pc_i + 4, truncated to PC_W (wraps at 2**PC_W).
  - When miss = 0: flush_o <= 0 and redirect_pc_o holds its value.
- Latency: resolution → flush_o is exactly 1 cycle. flush_o is never high for two consecutive cycles unless two consecutive mispredicts resolve.
- Statistics:
  - branch_cnt_o increments by 1 per cycle with res_valid_i = 1;
  - miss_cnt_o increments by 1 per cycle with miss = 1;
  - both stop at 2**CNT_W − 1 and never wrap.
- Reset asserted mid-operation:
  - all state clears immediately;
  - a pending flush is discarded, so flush_o = 0 during and after reset;
  - the first edge after release behaves as after power-up.
- res_* inputs are ignored when res_valid_i = 0; X on those inputs must not propagate into state.

Decomposition:
- Shared package (cpu_pkg), constants only:
  - counter state encodings SNT/WNT/WT/ST;
  - default IDX_W;
  - PC increment constant (4).
- Sub-module: sat_counter2, the combinational next-state function for one 2-bit entry (inputs: state, taken). It is instantiated once, on the update path only.
- The table, flush register and statistics counters live in branch_predictor.

Test Plan:
1. Reset, then pred_pc_i = 0x0000_0040 → pred_taken_o = 0 (WNT); flush_o = 0; both stats counters = 0.
2. Taken resolution of PC 0x40, res_pred_i = 0, target 0x100 → next cycle flush_o = 1, redirect_pc_o = 0x100, miss_cnt_o = 1. Entry becomes WT, so pred_taken_o for 0x40 = 1. A second taken resolution → ST and flush_o = 0.
3. Not-taken resolution of PC 0x40 from ST, res_pred_i = 1 → flush_o = 1 one cycle later, redirect_pc_o = 0x44, entry = WT. Meanwhile PC 0x140 (same index, IDX_W = 6) reads the same entry.
4. pred_pc_i = res_pc_i = 0x80 in the same cycle, entry WNT, res_taken_i = 1 → pred_taken_o = 0 in that cycle and 1 in the following cycle.
5. Force both counters to 0xFFFE and apply three mispredicting resolutions → both reach 0xFFFF and hold. res_pc_i = 0xFFFF_FFFC, not taken, mispredicted → redirect_pc_o = 0x0000_0000.
6. Assert rst_i asynchronously, mid-cycle, in the cycle between a mispredict and its flush → flush_o stays 0, all entries read WNT, stats = 0.
